program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter INS_ADDR_WIDTH, 6: program memory address width.
REQ-002 Parameter INS_WIDTH, 13: instruction width; SHALL be 9..16.
REQ-003 Parameter PM_DEPTH, 64: maximum words loadable; SHALL equal 2**INS_ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 nReset  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  sampled high in IDLE, DONE or ERR: begins a load.
REQ-007 ByteIn  input  8  stream data.
REQ-008 ByteValid  input  1  ByteIn valid.
REQ-009 ByteReady  output  1  loader accepts a byte; transfer on clk edge with ByteValid&ByteReady.
REQ-010 PM_WE  output  1  program memory write strobe, one clk per word.
REQ-011 PM_Addr  output  INS_ADDR_WIDTH  write address.
REQ-012 PM_Data  output  INS_WIDTH  write instruction.
REQ-013 CoreHold  output  1  high keeps the core's PC/registers held in reset while loading.
REQ-014 Busy  output  1  high in COUNT, LO, HI, LAST, CHK.
REQ-015 Done  output  1  high in DONE.
REQ-016 Error  output  1  high in ERR.

Function
REQ-017 States SHALL be IDLE, COUNT, LO, HI, LAST, CHK, DONE, ERR.
REQ-018 IDLE/DONE/ERR + Start -> COUNT; word counter, checksum cleared; CoreHold set; Start ignored in any other state.
REQ-019 ByteReady SHALL be 1 exactly in COUNT, LO, HI, CHK; bytes with ByteValid=0 SHALL not advance state.
REQ-020 COUNT: byte N accepted; N=0 or N>PM_DEPTH -> ERR, else -> LO.
REQ-021 LO: byte latched as PM_Data[7:0] -> HI.
REQ-022 HI: byte bits [INS_WIDTH-9:0] become PM_Data[INS_WIDTH-1:8]; any nonzero upper bit -> ERR with no write.
REQ-023 Valid HI accept: in the next cycle PM_WE=1, PM_Addr=word index (0 first), PM_Data=assembled word; counter increments.
REQ-024 After HI of word k<N-1 -> LO; LO byte may be accepted in the same cycle PM_WE is high.
REQ-025 After HI of word N-1 -> LAST (without checksum) or CHK (with); the final PM_WE occurs in that first cycle.
REQ-026 LAST: ByteReady=0, one cycle, -> DONE.
REQ-027 DONE: CoreHold=0, Done=1, held until Start.
REQ-028 ERR: CoreHold=1, Error=1, no further PM_WE, held until Start.
REQ-029 PM_WE SHALL never be high for two consecutive cycles; PM_Addr never wraps (max PM_DEPTH-1).
REQ-030 PM_Addr/PM_Data SHALL hold last written values when PM_WE=0.

Reset
REQ-031 nReset low SHALL immediately force IDLE, PM_WE=0, PM_Addr=0, PM_Data=0, ByteReady=0, CoreHold=0, Busy=0, Done=0, Error=0, counter/checksum=0.
REQ-032 Reset mid-load SHALL abort with no further write; memory contents already written are not restored.

Configuration
REQ-033 Macro PROGRAM_LOADER_CHECKSUM_EN defined: CHK state present; one extra byte SHALL equal XOR of count byte and all data bytes; match -> DONE, mismatch -> ERR.
REQ-034 Macro undefined: no CHK state, no checksum logic; HI of last word -> LAST -> DONE.

Structure
REQ-035 Shared package uproc_pkg SHALL hold the loader state enum, INS_WIDTH/INS_ADDR_WIDTH defaults and byte-width constant.
REQ-036 Sub-module loader_checksum (XOR accumulator with clear/enable) SHALL exist only under PROGRAM_LOADER_CHECKSUM_EN.

Verification
REQ-037 Start, bytes 02,34,12,FF,1F (no checksum) -> PM_WE at addr 0 data 0x1234, addr 1 data 0x1FFF; LAST then Done=1, CoreHold=0.
REQ-038 Count byte 00 -> Error=1, CoreHold=1, PM_WE never asserted; Start then valid load -> Done.
REQ-039 Count 01, LO 55, HI 20 -> Error=1, no PM_WE.
REQ-040 ByteValid toggled 1/0 every cycle, count 40 (64 words) -> 64 writes addr 0..63, ascending, no wrap, Done=1.
REQ-041 Checksum build: 01,AA,05,AE -> write 0x05AA, Done; same with 00 checksum -> Error=1.
REQ-042 nReset low after second word's HI accept -> no third write, all outputs at REQ-031 values in same cycle.

Source files
------------

// File: rtl/uproc_pkg.sv
// Shared loader definitions: state encoding, default widths, stream byte width.
// ST_CHK only exists in builds with PROGRAM_LOADER_CHECKSUM_EN defined.
package uproc_pkg;

  localparam int BYTE_W             = 8;
  localparam int INS_WIDTH_DEF      = 13;
  localparam int INS_ADDR_WIDTH_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_LO    = 3'd2,
    ST_HI    = 3'd3,
    ST_LAST  = 3'd4,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ST_CHK   = 3'd5,
`endif
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } loader_state_t;

endpackage

// File: rtl/program_loader_checksum.sv
// Running XOR of accepted stream bytes; clear wins over enable, result visible next cycle.
// Present only with PROGRAM_LOADER_CHECKSUM_EN; no backpressure of its own.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
module loader_checksum
  import uproc_pkg::*;
(
  input  logic              clk,
  input  logic              nReset,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [BYTE_W-1:0] o_sum
);

  logic [BYTE_W-1:0] r_sum;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum ^ i_byte;
    end
  end

  assign o_sum = r_sum;

endmodule
`endif

// File: rtl/program_loader.sv
// Byte-stream program loader: count byte, then LO/HI per word; write strobe one cycle after HI accept.
// ByteReady drops outside COUNT/LO/HI/CHK; optional trailing XOR byte under PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import uproc_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = INS_ADDR_WIDTH_DEF,
  parameter int INS_WIDTH      = INS_WIDTH_DEF,
  parameter int PM_DEPTH       = 64
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic                      Start,
  input  logic [BYTE_W-1:0]         ByteIn,
  input  logic                      ByteValid,
  output logic                      ByteReady,
  output logic                      PM_WE,
  output logic [INS_ADDR_WIDTH-1:0] PM_Addr,
  output logic [INS_WIDTH-1:0]      PM_Data,
  output logic                      CoreHold,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Error
);

  localparam int CNT_W = INS_ADDR_WIDTH + 1;
  localparam int HI_W  = INS_WIDTH - BYTE_W;
  // HI byte bits that have no home in the instruction word
  localparam logic [BYTE_W-1:0] HI_MASK = BYTE_W'(16'hFF << HI_W);

  if (INS_WIDTH < 9 || INS_WIDTH > 16) begin : g_bad_width
    $error("program_loader: INS_WIDTH must be 9..16");
  end
  if (PM_DEPTH != (1 << INS_ADDR_WIDTH)) begin : g_bad_depth
    $error("program_loader: PM_DEPTH must equal 2**INS_ADDR_WIDTH");
  end

  loader_state_t             r_state, w_next;
  logic [CNT_W-1:0]          r_cnt, r_idx, w_idx_inc;
  logic [BYTE_W-1:0]         r_lo;
  logic                      r_we;
  logic [INS_ADDR_WIDTH-1:0] r_addr;
  logic [INS_WIDTH-1:0]      r_data;
  logic                      w_xfer, w_start, w_cnt_bad, w_hi_bad, w_last;

  assign w_xfer    = ByteValid & ByteReady;
  assign w_start   = Start & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERR));
  assign w_cnt_bad = (ByteIn == '0) || (32'(ByteIn) > 32'(PM_DEPTH));
  assign w_hi_bad  = |(ByteIn & HI_MASK);
  assign w_idx_inc = r_idx + CNT_W'(1);
  assign w_last    = (w_idx_inc == r_cnt);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] w_sum;

  loader_checksum u_checksum (
    .clk    (clk),
    .nReset (nReset),
    .i_clr  (w_start),
    .i_en   (w_xfer),
    .i_byte (ByteIn),
    .o_sum  (w_sum)
  );
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (Start) w_next = ST_COUNT;
      ST_COUNT: if (w_xfer) w_next = w_cnt_bad ? ST_ERR : ST_LO;
      ST_LO:    if (w_xfer) w_next = ST_HI;
      ST_HI: begin
        if (w_xfer) begin
          if (w_hi_bad) begin
            w_next = ST_ERR;
          end else if (w_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            w_next = ST_CHK;
`else
            w_next = ST_LAST;
`endif
          end else begin
            w_next = ST_LO;
          end
        end
      end
      ST_LAST: w_next = ST_DONE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHK: if (w_xfer) w_next = (ByteIn == w_sum) ? ST_DONE : ST_ERR;
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ByteReady = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    CoreHold  = 1'b1;
    case (r_state)
      ST_IDLE: CoreHold = 1'b0;
      ST_COUNT, ST_LO, ST_HI: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
      end
      ST_LAST: Busy = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
      end
`endif
      ST_DONE: begin
        CoreHold = 1'b0;
        Done     = 1'b1;
      end
      ST_ERR:  Error = 1'b1;
      default: CoreHold = 1'b0;
    endcase
  end

  // Address/data only move on a write, so they hold the last word between strobes
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_lo   <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_cnt <= '0;
        r_idx <= '0;
      end
      if (w_xfer && r_state == ST_COUNT) r_cnt <= CNT_W'(ByteIn);
      if (w_xfer && r_state == ST_LO)    r_lo  <= ByteIn;
      if (w_xfer && r_state == ST_HI && !w_hi_bad) begin
        r_we   <= 1'b1;
        r_addr <= r_idx[INS_ADDR_WIDTH-1:0];
        r_data <= {ByteIn[HI_W-1:0], r_lo};
        r_idx  <= w_idx_inc;
      end
    end
  end

  assign PM_WE   = r_we;
  assign PM_Addr = r_addr;
  assign PM_Data = r_data;

endmodule
